// File: rtl/memory_address_sequencer.sv
// Burst address generator: holds a base address and emits base, base+STRIDE, ...
// under a valid/ready handshake. Optional ALIGN_CHECK_EN adds align_err for unaligned starts.
module memory_address_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int STRIDE     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] address_in,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic                  abort,
  input  logic                  addr_ready,
  output logic                  addr_valid,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic                  last,
  output logic                  busy,
  output logic                  done,
`ifdef ALIGN_CHECK_EN
  output logic                  align_err,
`endif
  output logic                  dbg_state
);

  // Handshake: a beat moves when addr_valid && addr_ready on a rising edge;
  // while addr_ready is low, address_out and last hold; abort overrides both.
  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] STRIDE_W = ADDR_WIDTH'(STRIDE);

  state_t                 state, next_state;
  logic [LEN_WIDTH-1:0]   remaining;
  logic                   start_ok;
  logic                   final_xfer;

`ifdef ALIGN_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRIDE - 1);
  logic [ADDR_WIDTH-1:0] base;
  logic                  misaligned;

  // With load+start the incoming address is the burst base.
  assign base       = load ? address_in : address_out;
  assign misaligned = |(base & ALIGN_MASK);
  assign start_ok   = start && !misaligned;
`else
  assign start_ok   = start;
`endif

  assign final_xfer = (state == BURST) && !abort && addr_ready && (remaining == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_ok) next_state = BURST;
      BURST:   if (abort || final_xfer) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address_out <= '0;
      remaining   <= '0;
      done        <= 1'b0;
`ifdef ALIGN_CHECK_EN
      align_err   <= 1'b0;
`endif
    end else begin
      done <= final_xfer;
`ifdef ALIGN_CHECK_EN
      align_err <= (state == IDLE) && start && misaligned;
`endif
      if (state == IDLE) begin
        if (load)     address_out <= address_in;
        if (start_ok) remaining   <= len_in;
      end else if (!abort && addr_ready && (remaining != '0)) begin
        address_out <= address_out + STRIDE_W;
        remaining   <= remaining - LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    addr_valid = (state == BURST);
    busy       = (state == BURST);
    last       = (state == BURST) && (remaining == '0);
    dbg_state  = state;
  end

endmodule

// File: tb/tb_memory_address_sequencer.sv
// Directed bench for memory_address_sequencer: expected beats and done pulses are
// queued at issue time and popped by a monitor whenever the DUT presents them.
module tb_memory_address_sequencer;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] address_in;
  logic        start;
  logic [7:0]  len_in;
  logic        abort;
  logic        addr_ready;
  logic        addr_valid;
  logic [31:0] address_out;
  logic        last;
  logic        busy;
  logic        done;
  logic        dbg_state;
`ifdef ALIGN_CHECK_EN
  logic        align_err;
`endif

  logic [32:0] exp_q[$];
  int          done_q[$];
  int          total = 0;
  int          bad = 0;
  int          beats_seen = 0;

  memory_address_sequencer dut (
    .clk(clk), .reset(reset), .load(load), .address_in(address_in),
    .start(start), .len_in(len_in), .abort(abort), .addr_ready(addr_ready),
    .addr_valid(addr_valid), .address_out(address_out), .last(last),
    .busy(busy), .done(done),
`ifdef ALIGN_CHECK_EN
    .align_err(align_err),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (addr_valid && addr_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL beat_extra: got %0h expected none", address_out);
        end else begin
          check("beat", {31'd0, last, address_out}, {31'd0, exp_q.pop_front()});
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          total++; bad++;
          $display("FAIL done_extra: got 1 expected 0");
        end else begin
          check("done_pulse", 64'(done), 64'(done_q.pop_front()));
        end
      end
    end
  end

  // drivers
  task automatic push_burst(input logic [31:0] base, input int len);
    for (int i = 0; i <= len; i++)
      exp_q.push_back({(i == len), base + 32'(i * 4)});
    done_q.push_back(1);
  endtask

  task automatic issue(input logic [31:0] base, input logic [7:0] len, input logic do_load);
    @(posedge clk); #1;
    load = do_load; address_in = base; start = 1'b1; len_in = len;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int n);
    n = 0;
    while (n < bound && (exp_q.size() != 0 || done_q.size() != 0)) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      total++; bad++;
      $display("FAIL wait_timeout: got %0d pending expected 0", exp_q.size() + done_q.size());
    end
  endtask

  initial begin
    int n;
    int b0;
    logic [3:0] pat;
    reset = 1'b1; load = 1'b1; address_in = 32'h1234; start = 1'b0;
    len_in = '0; abort = 1'b0; addr_ready = 1'b0;

    // 1: reset dominates load
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_address", address_out, 32'h0);
    check("rst_valid", addr_valid, 0);
    check("rst_last", last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    load = 1'b0; reset = 1'b0;

    // 2: plain register load
    @(posedge clk); #1; load = 1'b1; address_in = 32'h100;
    @(posedge clk); #1; load = 1'b0;
    @(negedge clk);
    check("load_address", address_out, 32'h100);
    check("load_valid", addr_valid, 0);

    // 3: load+start, always ready
    addr_ready = 1'b1;
    push_burst(32'h100, 3);
    issue(32'h100, 8'd3, 1'b1);
    wait_idle(20, n);
    check("burst_cycles", n, 5);
    @(negedge clk);
    check("burst_final_addr", address_out, 32'h10C);
    check("burst_idle_busy", busy, 0);

    // 4: same burst, ready pattern 1,0,0,1
    pat = 4'b1001;
    b0 = beats_seen;
    push_burst(32'h100, 3);
    issue(32'h100, 8'd3, 1'b1);
    for (int k = 0; k < 40 && (exp_q.size() != 0 || done_q.size() != 0); k++) begin
      addr_ready = pat[k % 4];
      @(posedge clk); #1;
    end
    wait_idle(10, n);
    check("toggle_transfers", beats_seen - b0, 4);
    addr_ready = 1'b1;

    // 5: address wrap
    push_burst(32'hFFFF_FFF8, 3);
    issue(32'hFFFF_FFF8, 8'd3, 1'b1);
    wait_idle(20, n);
    @(negedge clk);
    check("wrap_final_addr", address_out, 32'h4);

    // single-beat burst from the loaded address, start without load
    @(posedge clk); #1; load = 1'b1; address_in = 32'h40;
    @(posedge clk); #1; load = 1'b0;
    push_burst(32'h40, 0);
    issue(32'h0, 8'd0, 1'b0);
    wait_idle(20, n);
    check("single_cycles", n, 2);

    // 6: abort after second transfer, load during burst ignored
    exp_q.push_back({1'b0, 32'h200});
    exp_q.push_back({1'b0, 32'h204});
    @(posedge clk); #1; load = 1'b1; start = 1'b1; address_in = 32'h200; len_in = 8'd5;
    @(posedge clk); #1; load = 1'b0; start = 1'b0;
    @(posedge clk); #1; load = 1'b1; address_in = 32'hAAA0;
    @(posedge clk); #1; load = 1'b0; addr_ready = 1'b0; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    check("abort_valid", addr_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_address", address_out, 32'h208);
    check("abort_beats_left", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1; addr_ready = 1'b1;

`ifdef ALIGN_CHECK_EN
    @(posedge clk); #1; load = 1'b1; start = 1'b1; address_in = 32'h102; len_in = 8'd2;
    @(posedge clk); #1; load = 1'b0; start = 1'b0;
    @(negedge clk);
    check("align_err_pulse", align_err, 1);
    check("align_busy", busy, 0);
    check("align_address", address_out, 32'h102);
    @(negedge clk);
    check("align_err_clear", align_err, 0);
`else
    push_burst(32'h102, 1);
    issue(32'h102, 8'd1, 1'b1);
    wait_idle(20, n);
    @(negedge clk);
    check("unaligned_final", address_out, 32'h106);
`endif

    repeat (3) @(posedge clk);
    check("exp_q_empty", exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
